// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a downstream uart_tx through an IDLE/SEND/HOLD/WAIT drain FSM.
// Define UART_TX_FIFO_CRLF_EN to expand each popped LF (0x0A) into a CR (0x0D) followed by the LF.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_strobe,
  output logic                  in_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  dropped,
  output logic [7:0]            tx_data,
  output logic                  tx_strobe,
  input  logic                  tx_ready
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StSend, StHold, StWait} state_e;

  state_e                state_q, state_d;
  logic [7:0]            mem_q [Depth];
  logic [DEPTH_LOG2-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  dropped_q, dropped_d;
  logic                  full, wr_accept, pop, load;
  logic [7:0]            head;

`ifdef UART_TX_FIFO_CRLF_EN
  logic                  lf_pending_q, lf_pending_d;
`endif

  assign full      = (count_q == DepthCnt);
  assign wr_accept = in_strobe && !full;
  assign head      = mem_q[rd_q];

`ifdef UART_TX_FIFO_CRLF_EN
  // A pending LF is sent from the register without touching the FIFO.
  assign pop  = (state_q == StIdle) && tx_ready && (count_q != '0) && !lf_pending_q;
  assign load = (state_q == StIdle) && tx_ready && ((count_q != '0) || lf_pending_q);
`else
  assign pop  = (state_q == StIdle) && tx_ready && (count_q != '0);
  assign load = pop;
`endif

  always_comb begin
    state_d   = state_q;
    tx_strobe = 1'b0;
    unique case (state_q)
      StIdle: if (load) state_d = StSend;
      // Hold the strobe back rather than fire it at a busy transmitter.
      StSend: begin
        if (tx_ready) begin
          tx_strobe = 1'b1;
          state_d   = StHold;
        end
      end
      StHold: state_d = StWait;
      StWait: if (tx_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    tx_data_d = tx_data_q;
    dropped_d = in_strobe && full;
    if (wr_accept) wr_d = wr_q + DEPTH_LOG2'(1);
    if (pop) begin
      rd_d      = rd_q + DEPTH_LOG2'(1);
      tx_data_d = head;
    end
    unique case ({wr_accept, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
`ifdef UART_TX_FIFO_CRLF_EN
    lf_pending_d = lf_pending_q;
    if (pop && head == 8'h0A) begin
      tx_data_d    = 8'h0D;
      lf_pending_d = 1'b1;
    end else if (load && lf_pending_q) begin
      tx_data_d    = 8'h0A;
      lf_pending_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      tx_data_q <= '0;
      dropped_q <= 1'b0;
`ifdef UART_TX_FIFO_CRLF_EN
      lf_pending_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      tx_data_q <= tx_data_d;
      dropped_q <= dropped_d;
`ifdef UART_TX_FIFO_CRLF_EN
      lf_pending_q <= lf_pending_d;
`endif
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) mem_q[wr_q] <= in_data;
  end

  assign in_ready = !full;
  assign count    = count_q;
  assign dropped  = dropped_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo; honours UART_TX_FIFO_CRLF_EN for the LF case.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_strobe = 1'b0;
  logic       in_ready;
  logic [4:0] count;
  logic       dropped;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       tx_ready;

  logic       use_model = 1'b0;
  logic       man_rdy = 1'b1;
  int         busy = 0;
  int         cyc = 0;
  int         viol = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sent_data [$];
  int         sent_cyc [$];

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_strobe (in_strobe),
    .in_ready  (in_ready),
    .count     (count),
    .dropped   (dropped),
    .tx_data   (tx_data),
    .tx_strobe (tx_strobe),
    .tx_ready  (tx_ready)
  );

  always #5 clk = ~clk;

  // Model uart_tx: busy for 10 cycles after each load.
  assign tx_ready = use_model ? (busy == 0) : man_rdy;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) busy <= 0;
    else if (tx_strobe) busy <= 10;
    else if (busy != 0) busy <= busy - 1;
  end

  always @(negedge clk) begin
    if (!reset && tx_strobe) begin
      sent_data.push_back(tx_data);
      sent_cyc.push_back(cyc);
      if (!tx_ready) viol = viol + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    sent_data.delete();
    sent_cyc.delete();
    viol = 0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k;
    k = 0;
    while (sent_data.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_strobe = 1'b1;
    in_data = 8'h99;
    step();
    step();
    reset = 1'b0;
    in_strobe = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (tx_strobe !== 1'b0) begin errors++; $display("FAIL reset_tx_strobe: got %b expected 0", tx_strobe); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b expected 0", dropped); end
    step();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_write_ignored: count %0d expected 0", count); end
  endtask

  task automatic test_latency();
    man_rdy = 1'b1;
    in_data = 8'h41;
    in_strobe = 1'b1;
    step();
    in_strobe = 1'b0;
    checks++; if (tx_strobe !== 1'b0) begin errors++; $display("FAIL lat_early: tx_strobe %b expected 0", tx_strobe); end
    step();
    checks++; if (tx_strobe !== 1'b1) begin errors++; $display("FAIL lat_strobe: tx_strobe %b expected 1", tx_strobe); end
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL lat_data: got %h expected 41", tx_data); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL lat_count: got %0d expected 0", count); end
    step();
    checks++; if (tx_strobe !== 1'b0) begin errors++; $display("FAIL lat_one_cycle: tx_strobe %b expected 0", tx_strobe); end
    repeat (4) step();
  endtask

  task automatic test_fill_drop();
    man_rdy = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i);
      in_strobe = 1'b1;
      step();
    end
    in_strobe = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_count: got %0d expected 16", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    in_data = 8'hAA;
    in_strobe = 1'b1;
    step();
    in_strobe = 1'b0;
    checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL drop_pulse: got %b expected 1", dropped); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL drop_count: got %0d expected 16", count); end
    step();
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL drop_width: got %b expected 0", dropped); end
  endtask

  task automatic test_drain_model();
    clear_log();
    use_model = 1'b1;
    wait_strobes(16, 400);
    repeat (20) step();
    checks++; if (sent_data.size() != 16) begin errors++; $display("FAIL drain_n: got %0d strobes expected 16", sent_data.size()); end
    for (int i = 0; i < sent_data.size() && i < 16; i++) begin
      checks++;
      if (sent_data[i] !== 8'(i)) begin errors++; $display("FAIL drain_byte%0d: got %h expected %h", i, sent_data[i], 8'(i)); end
    end
    for (int i = 1; i < sent_cyc.size(); i++) begin
      checks++;
      if (sent_cyc[i] - sent_cyc[i-1] < 11) begin
        errors++; $display("FAIL drain_gap%0d: got %0d cycles expected >= 11", i, sent_cyc[i] - sent_cyc[i-1]);
      end
    end
    checks++; if (viol != 0) begin errors++; $display("FAIL drain_busy_strobe: got %0d expected 0", viol); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
    use_model = 1'b0;
    man_rdy = 1'b0;
    step();
  endtask

  task automatic test_simul_write_pop();
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h55;
    man_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = exp[i];
      in_strobe = 1'b1;
      step();
    end
    clear_log();
    in_data = 8'h55;
    man_rdy = 1'b1;
    step();
    in_strobe = 1'b0;
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL simul_count: got %0d expected 3", count); end
    checks++; if (tx_data !== 8'h11) begin errors++; $display("FAIL simul_head: got %h expected 11", tx_data); end
    wait_strobes(4, 100);
    checks++; if (sent_data.size() != 4) begin errors++; $display("FAIL simul_n: got %0d expected 4", sent_data.size()); end
    for (int i = 0; i < sent_data.size() && i < 4; i++) begin
      checks++;
      if (sent_data[i] !== exp[i]) begin errors++; $display("FAIL simul_byte%0d: got %h expected %h", i, sent_data[i], exp[i]); end
    end
    repeat (10) step();
  endtask

  task automatic test_reset_in_wait();
    man_rdy = 1'b0;
    step();
    for (int i = 1; i <= 6; i++) begin
      in_data = 8'(i);
      in_strobe = 1'b1;
      step();
    end
    in_strobe = 1'b0;
    man_rdy = 1'b1;
    step();
    step();
    man_rdy = 1'b0;
    step();
    step();
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL rstw_queued: got %0d expected 5", count); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rstw_count: got %0d expected 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstw_in_ready: got %b expected 1", in_ready); end
    clear_log();
    man_rdy = 1'b1;
    repeat (30) step();
    checks++; if (sent_data.size() != 0) begin errors++; $display("FAIL rstw_no_strobe: got %0d strobes expected 0", sent_data.size()); end
    in_data = 8'h77;
    in_strobe = 1'b1;
    step();
    in_strobe = 1'b0;
    wait_strobes(1, 20);
    checks++; if (sent_data.size() != 1) begin errors++; $display("FAIL rstw_new_n: got %0d expected 1", sent_data.size()); end
    if (sent_data.size() > 0) begin
      checks++;
      if (sent_data[0] !== 8'h77) begin errors++; $display("FAIL rstw_new_data: got %h expected 77", sent_data[0]); end
    end
    repeat (10) step();
  endtask

  task automatic test_crlf();
    logic [7:0] exp [$];
`ifdef UART_TX_FIFO_CRLF_EN
    exp = '{8'h48, 8'h0D, 8'h0A};
`else
    exp = '{8'h48, 8'h0A};
`endif
    clear_log();
    man_rdy = 1'b1;
    in_data = 8'h48;
    in_strobe = 1'b1;
    step();
    in_data = 8'h0A;
    step();
    in_strobe = 1'b0;
    wait_strobes(exp.size(), 100);
    repeat (20) step();
    checks++; if (sent_data.size() != exp.size()) begin errors++; $display("FAIL crlf_n: got %0d expected %0d", sent_data.size(), exp.size()); end
    for (int i = 0; i < sent_data.size() && i < exp.size(); i++) begin
      checks++;
      if (sent_data[i] !== exp[i]) begin errors++; $display("FAIL crlf_byte%0d: got %h expected %h", i, sent_data[i], exp[i]); end
    end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL crlf_count: got %0d expected 0", count); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_drop();
    test_drain_model();
    test_simul_write_pop();
    test_reset_in_wait();
    test_crlf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, SHALL set FIFO depth to 2**DEPTH_LOG2 bytes.
REQ-002 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 in_data  input  8  SHALL carry the byte to enqueue.
REQ-005 in_strobe  input  1  SHALL request a write of in_data this cycle.
REQ-006 in_ready  output  1  SHALL be high when the FIFO is not full.
REQ-007 count  output  DEPTH_LOG2+1  SHALL give the number of stored bytes.
REQ-008 dropped  output  1  SHALL pulse for one cycle when a write is discarded.
REQ-009 tx_data  output  8  SHALL carry the byte presented to the downstream uart_tx.
REQ-010 tx_strobe  output  1  SHALL be a one-cycle load pulse to the downstream uart_tx.
REQ-011 tx_ready  input  1  SHALL be the downstream uart_tx ready flag.

Function
REQ-012 Storage SHALL be a circular buffer with rd/wr pointers of DEPTH_LOG2 bits, wrapping modulo depth.
REQ-013 A write with in_strobe=1 and count<depth SHALL store in_data at wr and advance wr by one.
REQ-014 A write with count==depth SHALL be discarded, pointers unchanged, dropped=1 next cycle; this holds even if a pop occurs in the same cycle.
REQ-015 Simultaneous accepted write and pop SHALL leave count unchanged.
REQ-016 Drain FSM states SHALL be IDLE, SEND, HOLD, WAIT.
REQ-017 IDLE->SEND SHALL occur when count>0 and tx_ready=1; the byte at rd SHALL be popped and registered into tx_data on that edge.
REQ-018 SEND SHALL assert tx_strobe for exactly one cycle, then go to HOLD.
REQ-019 HOLD SHALL ignore tx_ready for one cycle (downstream ready is stale), then go to WAIT.
REQ-020 WAIT SHALL return to IDLE on the first cycle tx_ready=1.
REQ-021 tx_data SHALL stay stable from SEND until the next IDLE->SEND transition.
REQ-022 Minimum latency SHALL be: write at cycle N, tx_strobe at cycle N+2, given an empty FIFO and tx_ready=1.
REQ-023 tx_strobe SHALL never assert while tx_ready=0 or in any state other than SEND.

Reset
REQ-024 Reset SHALL set rd=wr=0, count=0, state=IDLE, tx_strobe=0, tx_data=0, dropped=0, in_ready=1.
REQ-025 Reset during SEND/HOLD/WAIT SHALL abort the transfer and discard all stored bytes; no strobe SHALL follow reset.
REQ-026 Writes presented in a reset cycle SHALL be ignored.

Configuration
REQ-027 Macro UART_TX_FIFO_CRLF_EN defined: popping byte 0x0A SHALL first send 0x0D via a full SEND/HOLD/WAIT cycle, then send 0x0A without re-reading the FIFO; pointer advance occurs on the 0x0D send.
REQ-028 UART_TX_FIFO_CRLF_EN undefined: all bytes SHALL be sent unmodified, and no CR-tracking logic SHALL be present.

Verification
REQ-029 Reset, then write 0x41 with tx_ready=1 -> tx_strobe exactly 2 cycles later with tx_data=0x41; count returns to 0.
REQ-030 Write 16 bytes 0x00..0x0F with tx_ready=0 -> count=16, in_ready=0; a 17th write -> dropped pulse, count stays 16.
REQ-031 Set tx_ready=1 after the fill, with a model uart_tx deasserting ready for 10 cycles per byte -> strobes carry 0x00..0x0F in order, one per ready period, none while ready=0.
REQ-032 Write 0x55 while the FIFO holds 3 bytes and a pop happens in the same cycle -> count stays 3, 0x55 is sent last.
REQ-033 Assert reset in WAIT with 5 bytes queued -> count=0, no tx_strobe follows until a new write.
REQ-034 With UART_TX_FIFO_CRLF_EN, write 0x48,0x0A -> strobes 0x48,0x0D,0x0A; without the macro -> 0x48,0x0A.
